// File: rtl/circuito_exp5.sv
// Memory-matching game: the player repeats a 16-word ROM sequence on one-hot keys,
// with a per-play time limit and seven-segment debug views of address, word and state.
module circuito_exp5 #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       nivel_jogadas,
  input  logic       nivel_tempo,
  input  logic [3:0] chaves,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_nivel,
  output logic       db_meioTempo,
  output logic       db_fimTempo
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(TIMEOUT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_MID  = CW'(TIMEOUT_CYCLES / 2);
  localparam logic [CW-1:0] HALF_MID  = CW'((TIMEOUT_CYCLES / 2) / 2);

  // Encodings double as the db_estado hex digit.
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMA     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    play_q, play_d;
  logic [CW-1:0] count_q, count_d;
  logic          nivel_jog_q, nivel_jog_d;
  logic          nivel_tempo_q, nivel_tempo_d;
  logic          tem_jogada_q;

  logic          tem_jogada, jogada, igual, fim_tempo, ultimo;
  logic [3:0]    rom_word;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;  // segments are active-low
  endfunction

  always_comb begin
    case (addr_q)
      4'h0: rom_word = 4'h1;  4'h1: rom_word = 4'h2;  4'h2: rom_word = 4'h4;  4'h3: rom_word = 4'h8;
      4'h4: rom_word = 4'h4;  4'h5: rom_word = 4'h2;  4'h6: rom_word = 4'h1;  4'h7: rom_word = 4'h1;
      4'h8: rom_word = 4'h2;  4'h9: rom_word = 4'h2;  4'hA: rom_word = 4'h4;  4'hB: rom_word = 4'h4;
      4'hC: rom_word = 4'h8;  4'hD: rom_word = 4'h8;  4'hE: rom_word = 4'h1;  default: rom_word = 4'h4;
    endcase
  end

  assign tem_jogada = |chaves;
  assign jogada     = tem_jogada & ~tem_jogada_q;
  assign igual      = (play_q == rom_word);
  assign ultimo     = (addr_q == (nivel_jog_q ? 4'hF : 4'h7));
  assign fim_tempo  = (count_q == (nivel_tempo_q ? HALF_M1 : FULL_M1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= INICIAL;
      addr_q        <= '0;
      play_q        <= '0;
      count_q       <= '0;
      nivel_jog_q   <= 1'b0;
      nivel_tempo_q <= 1'b0;
      tem_jogada_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      play_q        <= play_d;
      count_q       <= count_d;
      nivel_jog_q   <= nivel_jog_d;
      nivel_tempo_q <= nivel_tempo_d;
      tem_jogada_q  <= tem_jogada;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    play_d        = play_q;
    count_d       = count_q;
    nivel_jog_d   = nivel_jog_q;
    nivel_tempo_d = nivel_tempo_q;
    acertou       = 1'b0;
    errou         = 1'b0;
    pronto        = 1'b0;
    timeout       = 1'b0;
    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARACAO;
      PREPARACAO: begin
        addr_d        = '0;
        play_d        = '0;
        count_d       = '0;
        nivel_jog_d   = nivel_jogadas;
        nivel_tempo_d = nivel_tempo;
        state_d       = ESPERA;
      end
      ESPERA: begin
        if (jogada)         state_d = REGISTRA;
        else if (fim_tempo) state_d = FIM_TIMEOUT;
        else                count_d = count_q + CW'(1);
      end
      REGISTRA: begin
        play_d  = chaves;
        state_d = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)      state_d = FIM_ERRO;
        else if (ultimo) state_d = FIM_ACERTO;
        else             state_d = PROXIMA;
      end
      PROXIMA: begin
        addr_d  = addr_q + 4'd1;
        count_d = '0;
        state_d = ESPERA;
      end
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) state_d = PREPARACAO;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) state_d = PREPARACAO;
      end
      FIM_TIMEOUT: begin
        pronto  = 1'b1;
        errou   = 1'b1;
        timeout = 1'b1;
        if (iniciar) state_d = PREPARACAO;
      end
      default: state_d = INICIAL;
    endcase
  end

  assign leds          = play_q;
  assign db_igual      = igual;
  assign db_contagem   = hex7seg(addr_q);
  assign db_memoria    = hex7seg(rom_word);
  assign db_estado     = hex7seg(state_q);
  assign db_clock      = clock;
  assign db_iniciar    = iniciar;
  assign db_tem_jogada = tem_jogada;
  assign db_nivel      = nivel_jog_q;
  // The timer freezes outside espera_jogada, so the end-of-time flag is qualified by state.
  assign db_fimTempo   = (state_q == ESPERA) && fim_tempo;
  assign db_meioTempo  = (count_q >= (nivel_tempo_q ? HALF_MID : FULL_MID));

endmodule

// File: tb/tb_circuito_exp5.sv
// Bench for circuito_exp5: table-driven plays, a scoreboard of registered plays
// checked in the comparison state, and timing sequences for the play time limit.
module tb_circuito_exp5;

  logic       clock = 1'b0;
  logic       reset, iniciar, nivel_jogadas, nivel_tempo;
  logic [3:0] chaves;
  logic       acertou, errou, pronto, timeout, db_igual;
  logic [3:0] leds;
  logic [6:0] db_contagem, db_memoria, db_estado;
  logic       db_clock, db_iniciar, db_tem_jogada, db_nivel, db_meioTempo, db_fimTempo;

  circuito_exp5 #(.TIMEOUT_CYCLES(5000)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .nivel_jogadas(nivel_jogadas),
    .nivel_tempo(nivel_tempo), .chaves(chaves), .acertou(acertou), .errou(errou),
    .pronto(pronto), .timeout(timeout), .leds(leds), .db_igual(db_igual),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_estado(db_estado),
    .db_clock(db_clock), .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada),
    .db_nivel(db_nivel), .db_meioTempo(db_meioTempo), .db_fimTempo(db_fimTempo)
  );

  always #5 clock = ~clock;

  // Active-low gfedcba codes of the states and digits the bench looks at.
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S7 = 7'h78, S8 = 7'h00;
  localparam logic [6:0] SA = 7'h08, SC = 7'h12, SD = 7'h21, SE = 7'h06, SF = 7'h0E;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;
  logic [3:0] rom_m [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                             4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
  logic [3:0] addr_m;
  logic       lvl_m;

  typedef struct {
    logic [3:0] key;
    bit         registers;
    logic [6:0] estado;
    logic [6:0] contagem;
    logic [3:0] leds;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each registered play is compared while the DUT sits in comparacao.
  always @(negedge clock) begin
    if (!reset && db_estado == SC) begin
      if (exp_q.size() == 0) begin
        check("unexpected_compare", 32'(1), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("cmp_leds", 32'(leds), 32'(mon_e[3:0]));
        check("cmp_igual", 32'(db_igual), 32'(mon_e[4]));
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Returns on the negedge after the DUT has entered espera_jogada with the timer at 0.
  task automatic start_game(input logic nj, input logic nt);
    @(negedge clock);
    iniciar = 1'b1; nivel_jogadas = nj; nivel_tempo = nt;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    addr_m = 4'h0;
    lvl_m  = nj;
  endtask

  task automatic play(input logic [3:0] key, input int hold, input int gap, input bit registers);
    logic exp_ig;
    @(negedge clock);
    chaves = key;
    if (registers) begin
      exp_ig = (key == rom_m[addr_m]);
      exp_q.push_back({exp_ig, key});
      if (exp_ig && addr_m != (lvl_m ? 4'd15 : 4'd7)) addr_m = addr_m + 4'd1;
    end
    repeat (hold) @(negedge clock);
    chaves = 4'h0;
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    failures++;
    $display("FAIL watchdog: got no end of test, expected end before 60000 cycles");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'h1, 1'b1, S2, S1,    4'h1};
    vecs[1] = '{4'h2, 1'b1, S2, S2,    4'h2};
    vecs[2] = '{4'h4, 1'b1, S2, 7'h30, 4'h4};
    vecs[3] = '{4'h8, 1'b1, S2, 7'h19, 4'h8};
    vecs[4] = '{4'h4, 1'b1, S2, 7'h12, 4'h4};
    vecs[5] = '{4'h2, 1'b1, S2, 7'h02, 4'h2};
    vecs[6] = '{4'h1, 1'b1, S2, S7,    4'h1};
    vecs[7] = '{4'h1, 1'b1, S2, S8,    4'h1};
    vecs[8] = '{4'h8, 1'b1, SE, S8,    4'h8};
    vecs[9] = '{4'h4, 1'b0, SE, S8,    4'h8};

    reset = 1'b1; iniciar = 1'b0; nivel_jogadas = 1'b0; nivel_tempo = 1'b0; chaves = 4'h0;
    addr_m = 4'h0; lvl_m = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_estado", 32'(db_estado), 32'(S0));
    check("rst_flags", 32'({acertou, errou, pronto, timeout}), 32'(0));
    check("rst_leds", 32'(leds), 32'(0));
    check("rst_contagem", 32'(db_contagem), 32'(S0));
    check("rst_memoria", 32'(db_memoria), 32'(S1));
    check("rst_nivel", 32'(db_nivel), 32'(0));
    check("db_clock_low", 32'(db_clock), 32'(0));
    @(posedge clock); #1;
    check("db_clock_high", 32'(db_clock), 32'(1));
    @(negedge clock);
    reset = 1'b0;

    // Idle in inicial, keys and time do not matter.
    chaves = 4'h4;
    @(negedge clock);
    check("db_tem_jogada", 32'(db_tem_jogada), 32'(1));
    chaves = 4'h0;
    repeat (5010) @(negedge clock);
    check("idle_estado", 32'(db_estado), 32'(S0));
    check("idle_timeout", 32'(timeout), 32'(0));
    iniciar = 1'b1;
    #1 check("db_iniciar", 32'(db_iniciar), 32'(1));
    iniciar = 1'b0;
    start_game(1'b0, 1'b0);
    repeat (5010) @(negedge clock);
    check("idle_game_timeout", 32'(timeout), 32'(1));
    check("idle_game_estado", 32'(db_estado), 32'(SD));

    // Sixteen-play game, wrong ninth play, then an ignored play.
    do_reset();
    start_game(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      play(vecs[i].key, 2, 4, vecs[i].registers);
      check($sformatf("vec%0d_estado", i), 32'(db_estado), 32'(vecs[i].estado));
      check($sformatf("vec%0d_contagem", i), 32'(db_contagem), 32'(vecs[i].contagem));
      check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].leds));
    end
    check("err_flags", 32'({acertou, errou, pronto, timeout}), 32'(4'b0110));

    // Full sixteen-word game with slow key presses.
    start_game(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) play(rom_m[i], 3, 10, 1'b1);
    check("win16_flags", 32'({acertou, errou, pronto, timeout}), 32'(4'b1010));
    check("win16_estado", 32'(db_estado), 32'(SA));
    check("win16_contagem", 32'(db_contagem), 32'(SF));
    check("win16_nivel", 32'(db_nivel), 32'(1));

    // Eight-play game started straight from fim_acerto.
    start_game(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) play(rom_m[i], 2, 4, 1'b1);
    check("win8_flags", 32'({acertou, errou, pronto, timeout}), 32'(4'b1010));
    check("win8_contagem", 32'(db_contagem), 32'(S7));
    check("win8_nivel", 32'(db_nivel), 32'(0));

    // Level input dropped mid-game: the latched sixteen-play level must hold.
    do_reset();
    start_game(1'b1, 1'b0);
    nivel_jogadas = 1'b0;
    for (int i = 0; i < 8; i++) play(rom_m[i], 2, 4, 1'b1);
    check("lvl_still_playing", 32'(db_estado), 32'(S2));
    check("lvl_memoria", 32'(db_memoria), 32'(S2));
    play(4'h8, 2, 4, 1'b1);
    check("lvl_errou", 32'(errou), 32'(1));
    check("lvl_estado", 32'(db_estado), 32'(SE));
    check("lvl_nivel", 32'(db_nivel), 32'(1));

    // Full time limit after one correct play; the timer is at 2 when play() returns.
    do_reset();
    start_game(1'b0, 1'b0);
    play(4'h1, 2, 4, 1'b1);
    repeat (2497) @(negedge clock);
    check("to_meio_before", 32'(db_meioTempo), 32'(0));
    @(negedge clock);
    check("to_meio_at", 32'(db_meioTempo), 32'(1));
    repeat (2498) @(negedge clock);
    check("to_fim_before", 32'(db_fimTempo), 32'(0));
    @(negedge clock);
    check("to_fim_at", 32'(db_fimTempo), 32'(1));
    check("to_still_waiting", 32'(db_estado), 32'(S2));
    @(negedge clock);
    check("to_flags", 32'({acertou, errou, pronto, timeout}), 32'(4'b0111));
    check("to_estado", 32'(db_estado), 32'(SD));
    check("to_fim_pulse_end", 32'(db_fimTempo), 32'(0));
    play(4'h2, 2, 4, 1'b0);
    check("to_ignored_estado", 32'(db_estado), 32'(SD));
    check("to_ignored_leds", 32'(leds), 32'(1));

    // Half time limit, with the time-level input dropped after the start.
    start_game(1'b0, 1'b1);
    nivel_tempo = 1'b0;
    repeat (1249) @(negedge clock);
    check("half_meio_before", 32'(db_meioTempo), 32'(0));
    @(negedge clock);
    check("half_meio_at", 32'(db_meioTempo), 32'(1));
    repeat (1249) @(negedge clock);
    check("half_fim_at", 32'(db_fimTempo), 32'(1));
    @(negedge clock);
    check("half_timeout", 32'(timeout), 32'(1));
    check("half_estado", 32'(db_estado), 32'(SD));

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circuito_exp5.md
CIRCUITO_EXP5 -- requirements
Module: circuito_exp5

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 5000, giving the per-play time limit in clock cycles when nivel_tempo=0.
REQ-002 clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 iniciar  in  1  starts a game, held for one or more cycles.
REQ-005 nivel_jogadas  in  1  game length: 0 = 8 plays, 1 = 16 plays.
REQ-006 nivel_tempo  in  1  time level: 0 = TIMEOUT_CYCLES, 1 = TIMEOUT_CYCLES/2.
REQ-007 chaves  in  4  player keys, one-hot play.
REQ-008 acertou, errou, pronto, timeout  out  1 each  game-result flags.
REQ-009 leds  out  4  last registered play.
REQ-010 db_igual  out  1  registered play equals current memory word.
REQ-011 db_contagem, db_memoria, db_estado  out  7 each  seven-segment debug displays.
REQ-012 db_clock, db_iniciar, db_tem_jogada, db_nivel, db_meioTempo, db_fimTempo  out  1 each  debug signals.

Function
REQ-013 The block SHALL hold a 16x4 ROM with words 0..15 = 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex).
REQ-014 A 4-bit address counter SHALL index the ROM; db_contagem SHALL show the address and db_memoria SHALL show the ROM word.
REQ-015 tem_jogada SHALL be the OR of chaves; a rising-edge detector SHALL produce a one-cycle jogada pulse on the first cycle chaves becomes nonzero.
REQ-016 FSM states and db_estado codes: inicial 0, preparacao 1, espera_jogada 2, registra 4, comparacao 5, proxima 6, fim_acerto A, fim_erro E, fim_timeout D.
REQ-017 inicial: go to preparacao when iniciar=1; otherwise stay.
REQ-018 preparacao (1 cycle): clear the address, the play register and the timer; latch nivel_jogadas and nivel_tempo; go to espera_jogada.
REQ-019 espera_jogada: on jogada pulse go to registra; else if the timer reaches its limit go to fim_timeout; else stay with the timer incrementing.
REQ-020 registra (1 cycle): load chaves into the play register; go to comparacao.
REQ-021 comparacao (1 cycle): if the play is unequal to the ROM word go to fim_erro; if equal and the address is last (7 for level 0, 15 for level 1) go to fim_acerto; otherwise go to proxima.
REQ-022 proxima (1 cycle): increment the address, clear the timer, go to espera_jogada.
REQ-023 Final states: pronto=1; acertou=1 in fim_acerto; errou=1 in fim_erro and fim_timeout; timeout=1 only in fim_timeout. Flags SHALL be 0 in all other states.
REQ-024 Final states SHALL ignore chaves and the timer, and SHALL go to preparacao on iniciar=1.
REQ-025 The latched level SHALL NOT change during a game; db_nivel SHALL show the latched nivel_jogadas.
REQ-026 The timer SHALL count only in espera_jogada.
REQ-027 db_fimTempo SHALL pulse at count = limit-1, which causes the fim_timeout transition.
REQ-028 db_meioTempo SHALL be 1 while count >= limit/2.
REQ-029 Seven-segment outputs SHALL be active-low, bit order gfedcba, encoding hex digits 0-F.
REQ-030 db_clock SHALL equal clock, db_iniciar SHALL equal iniciar, and db_tem_jogada SHALL equal tem_jogada.
REQ-031 leds SHALL equal the play register.

Reset
REQ-032 On reset=1 at a clock edge, the block SHALL enter inicial regardless of state or timer activity.
REQ-033 Reset SHALL clear the address, play register, timer and latched levels to 0.
REQ-034 After reset, all result flags and leds SHALL be 0 and db_estado SHALL show 0.
REQ-035 The block SHALL stay in inicial indefinitely after reset without iniciar; no timeout SHALL occur.

Verification
REQ-036 Reset, iniciar with nivel_jogadas=1, plays 1,2,4,8,4,2,1,1 correct, 9th play 8 -> errou=1, pronto=1, db_estado=E; further plays ignored.
REQ-037 iniciar with nivel_jogadas=1, all 16 ROM words played, each held 3 cycles with 10-cycle gaps -> acertou=1, pronto=1, db_contagem=F.
REQ-038 From fim_acerto, iniciar with nivel_jogadas=0, 8 correct plays -> acertou=1 after the 8th play, db_contagem=7.
REQ-039 Reset, iniciar with nivel_jogadas=1, then drop nivel_jogadas to 0, 8 correct plays then play 8 -> errou=1 (16-play level retained).
REQ-040 Timeout: after iniciar, one correct play then 5000 idle cycles (nivel_tempo=0) -> db_meioTempo=1 after 2500 cycles, then timeout=1, errou=1, db_estado=D; a later play has no effect.
REQ-041 Reset then wait 5010 cycles -> stays in inicial, timeout=0; then iniciar and wait 5010 cycles -> timeout=1.
